// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package: ALU control encodings, mult/div op codes, MDU state
// enumeration and small sign helpers used by the mult/div unit.
package mult_div_unit_pkg;

  // ALU control encodings used by the integer datapath
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_ctrl_e;

  // Mult/div unit op codes; 3'b11x are no-ops
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Mult/div unit sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Counter value loaded on start: 32 iterations, counting 31 down to 0
  localparam logic [4:0] MDU_FIRST_COUNT = 5'd31;

  // Two's-complement negate when the condition is set
  function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic c);
    return c ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic c);
    return c ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_core.sv
// Iterative 32-step datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. acc_hi/acc_lo hold product or remainder/quotient.
module mdu_core
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo,
  output logic        last
);

  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] b_reg;
  logic [4:0]  count_reg;
  logic        div_reg;

  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic [33:0] trial;
  logic        take;
  logic [31:0] hi_next;
  logic [31:0] lo_next;

  // One iteration: multiply adds multiplicand on LSB then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow
  always_comb begin
    add_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : 33'd0);
    rem_shift = {hi_reg, lo_reg[31]};
    trial     = {1'b0, rem_shift} - {2'b00, b_reg};
    take      = ~trial[33];
    hi_next   = add_sum[32:1];
    lo_next   = {add_sum[0], lo_reg[31:1]};
    if (div_reg) begin
      hi_next = take ? trial[31:0] : rem_shift[31:0];
      lo_next = {lo_reg[30:0], take};
    end
  end

  // Working registers and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      b_reg     <= 32'd0;
      count_reg <= 5'd0;
      div_reg   <= 1'b0;
    end else if (load) begin
      hi_reg    <= 32'd0;
      lo_reg    <= opa;
      b_reg     <= opb;
      count_reg <= MDU_FIRST_COUNT;
      div_reg   <= is_div;
    end else if (step) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= count_reg - 5'd1;
    end
  end

  assign acc_hi = hi_reg;
  assign acc_lo = lo_reg;
  assign last   = (count_reg == 5'd0);

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: FSM, operand sign handling and the HI/LO registers
// around the iterative mdu_core datapath. 34-cycle busy window per op.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state_reg;
  logic        neg_prod_reg;
  logic        neg_rem_reg;
  logic        div_reg;
  logic        div_zero_reg;
  logic        fix_stage_reg;
  logic [31:0] res_hi_reg;
  logic [31:0] res_lo_reg;

  logic        is_arith;
  logic        is_div;
  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        load;
  logic        step;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        last;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Decode the request and convert signed operands to magnitudes
  always_comb begin
    is_arith  = (op[2] == 1'b0);
    is_div    = op[1];
    is_signed = ~op[0];
    neg_a     = is_signed & opr1[31];
    neg_b     = is_signed & opr2[31];
    mag_a     = neg32_if(opr1, neg_a);
    mag_b     = neg32_if(opr2, neg_b);
    load      = (state_reg == ST_IDLE) && start && is_arith;
    step      = (state_reg == ST_CALC);
  end

  mdu_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .opa    (mag_a),
    .opb    (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .last   (last)
  );

  // Sign correction of the raw magnitude result; divide-by-zero forces all-ones quotient
  always_comb begin
    prod_fix = neg64_if({acc_hi, acc_lo}, neg_prod_reg);
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (div_reg) begin
      fix_hi = neg32_if(acc_hi, neg_rem_reg);
      fix_lo = div_zero_reg ? 32'hFFFF_FFFF : neg32_if(acc_lo, neg_prod_reg);
    end
  end

  // Control FSM; FIX takes two cycles so the negation is registered before HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      hi            <= 32'd0;
      lo            <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      neg_prod_reg  <= 1'b0;
      neg_rem_reg   <= 1'b0;
      div_reg       <= 1'b0;
      div_zero_reg  <= 1'b0;
      fix_stage_reg <= 1'b0;
      res_hi_reg    <= 32'd0;
      res_lo_reg    <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (is_arith) begin
              state_reg    <= ST_CALC;
              busy         <= 1'b1;
              neg_prod_reg <= neg_a ^ neg_b;
              neg_rem_reg  <= neg_a;
              div_reg      <= is_div;
              div_zero_reg <= (opr2 == 32'd0);
            end else if (op == OP_MTHI) begin
              hi <= opr1;
            end else if (op == OP_MTLO) begin
              lo <= opr1;
            end
          end
        end
        ST_CALC: begin
          if (last) begin
            state_reg     <= ST_FIX;
            fix_stage_reg <= 1'b0;
          end
        end
        ST_FIX: begin
          if (!fix_stage_reg) begin
            res_hi_reg    <= fix_hi;
            res_lo_reg    <= fix_lo;
            fix_stage_reg <= 1'b1;
          end else begin
            hi        <= res_hi_reg;
            lo        <= res_lo_reg;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .opr1 (opr1),
    .opr2 (opr2),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, count busy cycles, check result and done pulse.
  // mid_start: re-present a different start during CALC.
  // poke_done: present MTHI during the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit mid_start, input bit poke_done);
    int n;
    bit done_early;
    op = o; opr1 = a; opr2 = b; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    done_early = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done !== 1'b0) done_early = 1'b1;
      if (mid_start && n == 5) begin
        start = 1'b1; op = OP_DIVU; opr1 = 32'h55; opr2 = 32'h3;
      end
      if (mid_start && n == 6) start = 1'b0;
      tick;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'd34);
    chk({tag, " done_during_busy"}, 32'(done_early), 32'd0);
    chk({tag, " done_pulse"}, 32'(done), 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    $display("[TB] %s: hi=%h lo=%h busy_cycles=%0d", tag, hi, lo, n);
    if (poke_done) begin
      start = 1'b1; op = OP_MTHI; opr1 = 32'h0000_0055;
    end
    tick;
    start = 1'b0;
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    if (poke_done) chk({tag, " start_in_done_ignored"}, hi, eh);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 3'b000; opr1 = 32'd0; opr2 = 32'd0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    $display("[TB] reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);

    run_op("MULTU 7x6", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
    run_op("MULT -3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op("MULTU FFFFFFFDx5", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("DIV 1234/0", OP_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIVU 1234/0", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIV 80000000/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("MULTU 7x6 restart", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, 1'b0);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = OP_MTHI; opr1 = 32'hDEAD_BEEF;
    tick;
    chk("MTHI hi", hi, 32'hDEAD_BEEF);
    chk("MTHI busy", 32'(busy), 32'd0);
    chk("MTHI done", 32'(done), 32'd0);
    op = OP_MTLO; opr1 = 32'h1;
    tick;
    start = 1'b0;
    chk("MTLO lo", lo, 32'h1);
    chk("MTLO hi kept", hi, 32'hDEAD_BEEF);
    chk("MTLO busy", 32'(busy), 32'd0);
    chk("MTLO done", 32'(done), 32'd0);
    $display("[TB] MTHI/MTLO: hi=%h lo=%h", hi, lo);

    // 11x no-ops
    start = 1'b1; op = 3'b110; opr1 = 32'h7777_7777;
    tick;
    op = 3'b111;
    tick;
    start = 1'b0;
    chk("NOP busy", 32'(busy), 32'd0);
    chk("NOP hi", hi, 32'hDEAD_BEEF);
    chk("NOP lo", lo, 32'h1);
    $display("[TB] NOP: hi=%h lo=%h busy=%b", hi, lo, busy);

    // Reset at cycle 10 of a MULT
    start = 1'b1; op = OP_MULT; opr1 = 32'hFFFF_FFFD; opr2 = 32'd5;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort done", 32'(done), 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    chk("abort no activity", 32'(seen_done), 32'd0);
    chk("abort hi stays", hi, 32'd0);
    $display("[TB] reset abort: hi=%h lo=%h busy=%b", hi, lo, busy);

    run_op("DIVU 9/3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 opr1  input  32  multiplicand / dividend / MTHI-MTLO source.
REQ-007 opr2  input  32  multiplier / divisor.
REQ-008 busy  output  1  high while a mult/div is in progress; pipeline stalls on it.
REQ-009 done  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
REQ-010 hi  output  32  HI register, driven directly from a flop.
REQ-011 lo  output  32  LO register, driven directly from a flop.

Function
REQ-012 States: IDLE, CALC, FIX, DONE.
REQ-013 IDLE, start=1, op in {MULT,MULTU,DIV,DIVU} -> latch operand magnitudes, result-sign flags and op; load counter to 31; go to CALC.
REQ-014 IDLE, start=1, op=MTHI/MTLO -> hi/lo <= opr1 on that edge; state stays IDLE; busy stays 0; done stays 0.
REQ-015 Signed ops convert operands to magnitude; unsigned ops use operands as-is.
REQ-016 CALC performs one iteration per cycle for exactly 32 cycles: shift-add for multiply; restoring shift-subtract for divide; counter decrements; leave CALC when counter=0.
REQ-017 FIX applies two's-complement sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-018 Results: multiply -> {hi,lo} = 64-bit product; divide -> lo=quotient, hi=remainder; hi/lo written on the FIX->DONE edge.
REQ-019 Latency: start accepted at edge E0; busy=1 from E0 until E34; hi/lo updated and done=1 for exactly the cycle after E34 (state DONE); DONE -> IDLE on the next edge.
REQ-020 busy=0 in IDLE and DONE; start asserted while busy=1 is ignored with no side effects.
REQ-021 Divide by zero (either DIV or DIVU): lo=32'hFFFF_FFFF, hi=opr1; same 34-cycle latency.
REQ-022 DIV 0x8000_0000 / 0xFFFF_FFFF: lo=32'h8000_0000, hi=0; no trap, no flag.
REQ-023 start in DONE is ignored; it must be re-presented in IDLE.
REQ-024 op 11x with start=1 in IDLE: no state change.

Reset
REQ-025 rst=1 at any edge -> state IDLE, hi=0, lo=0, busy=0, done=0, counter and working registers cleared; overrides start.
REQ-026 rst during CALC/FIX aborts the operation; the partial result is never written to hi/lo.

Structure
REQ-027 Op encodings and the state enumeration are defined in the shared CPU package, next to the ALU control encodings.
REQ-028 One natural sub-module, mdu_core: the 32-step iterative shift/add-subtract datapath with counter; the top level holds the FSM, sign handling and HI/LO.
REQ-029 No multiplier or divider operators are inferred; only adders/subtractors are used.

Verification
REQ-030 MULTU 7 x 6 -> done after 34 cycles; hi=0, lo=42; busy high for exactly 34 cycles.
REQ-031 MULT 0xFFFF_FFFD x 5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; MULTU same operands -> hi=4, lo=32'hFFFF_FFF1.
REQ-032 DIVU 100 / 7 -> lo=14, hi=2; DIV 0xFFFF_FFF9 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-033 DIV and DIVU 0x1234 / 0 -> lo=32'hFFFF_FFFF, hi=0x1234; DIV 0x8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-034 MTHI 0xDEAD_BEEF, then MTLO 0x1 on consecutive cycles -> hi/lo updated on the following edges; busy and done never assert. A second start during CALC with a different op -> ignored; the first result is intact.
REQ-035 Assert rst at cycle 10 of a MULT -> next cycle state IDLE, hi=lo=0, busy=0, done never pulses; a fresh DIVU 9/3 then yields lo=3, hi=0.
